muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have port valid_i, input, 1: execute stage holds a mult/div instruction.
REQ-004 SHALL have port op_i, input, 2: operation, 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports a_i and b_i, input, 32 each: rs and rt operands, sampled only on accept.
REQ-006 SHALL have port flush_i, input, 1: abort the in-flight operation (exception or redirect).
REQ-007 SHALL have port ready_o, output, 1: state IDLE.
REQ-008 SHALL have port stall_o, output, 1: hold the pipeline front-end and execute stage.
REQ-009 SHALL have port done_o, output, 1: one-cycle result-valid pulse.
REQ-010 SHALL have ports hi_o and lo_o, output, 32 each: registered HI and LO results.

Function
REQ-011 SHALL implement the states IDLE, MUL, DIV, FIX and DONE.
REQ-012 SHALL accept a request when state is IDLE, valid_i=1 and flush_i=0, and SHALL latch op, operand signs and operand magnitudes (unsigned for MULTU/DIVU).
REQ-013 SHALL transition on accept to MUL for ops 00/01, to DIV for ops 1x with b_i!=0, and to DONE for ops 1x with b_i==0.
REQ-014 SHALL perform a 32-cycle shift-add multiply in MUL using a 5-bit counter, and SHALL go to FIX after count 31.
REQ-015 SHALL perform a 32-cycle restoring divide in DIV (one quotient bit per cycle), and SHALL go to FIX after count 31.
REQ-016 SHALL apply sign fixup in FIX, one cycle, then go to DONE:
  - MULT: negate the 64-bit product if sign(a) xor sign(b).
  - DIV: negate the quotient if sign(a) xor sign(b); negate the remainder if sign(a).
REQ-017 SHALL wrap all arithmetic modulo 2^32; 0x80000000 / 0xFFFFFFFF yields LO=0x80000000, HI=0.
REQ-018 SHALL produce divide-by-zero results HI=a_i and LO=0xFFFFFFFF for both DIV and DIVU.
REQ-019 SHALL load hi_o/lo_o only on the edge entering DONE (HI=product[63:32] or remainder, LO=product[31:0] or quotient); at all other times they SHALL hold their value.
REQ-020 SHALL assert done_o exactly while state is DONE; DONE SHALL always return to IDLE on the next edge.
REQ-021 SHALL ignore valid_i while in DONE, so the same instruction is not re-accepted.
REQ-022 SHALL drive stall_o = (IDLE and valid_i and not flush_i) or state in {MUL, DIV, FIX}; stall_o SHALL be 0 in DONE.
REQ-023 SHALL have a latency of 34 cycles from the accept edge to done_o for MUL and DIV, and 1 cycle for divide-by-zero.
REQ-024 SHALL return to IDLE on the next edge when flush_i=1 in MUL, DIV or FIX, with no done_o and hi_o/lo_o unchanged.
REQ-025 SHALL give flush_i priority over accept in IDLE.

Reset
REQ-026 SHALL force, on reset assertion (asynchronous, any state including mid-operation): state=IDLE, counter=0, hi_o=0, lo_o=0, done_o=0, stall_o=0, ready_o=1.
REQ-027 SHALL discard any partial result on reset.

Configuration
REQ-028 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute the product as a single-cycle registered 64-bit multiply, so that accept goes to FIX directly, MUL is unused and multiply latency is 2 cycles.
REQ-029 SHALL, without MULDIV_FAST_MUL_EN, use the iterative multiply of REQ-014; divide behaviour SHALL be identical in both builds.

Verification
REQ-030 SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001, done_o 34 cycles after accept (2 with MULDIV_FAST_MUL_EN).
REQ-031 SHALL cover MULT a=0xFFFFFFFD (-3), b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB, stall_o high through FIX and low in DONE.
REQ-032 SHALL cover DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 SHALL cover DIVU a=5, b=0 -> done_o one cycle after accept with HI=5, LO=0xFFFFFFFF.
REQ-034 SHALL cover DIVU 100/7, flush_i pulsed on the 10th DIV cycle -> no done_o, hi_o/lo_o keep prior values, ready_o=1 on the next cycle.
REQ-035 SHALL cover reset asserted mid-MUL -> immediate IDLE with outputs 0, then a fresh MULTU 6*7 completes with LO=42, HI=0.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered multiply (accept -> FIX).
module muldiv_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sign_a_q, sign_a_d;
  logic        sign_b_q, sign_b_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] work_hi_q, work_hi_d;
  logic [31:0] work_lo_q, work_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        accept;
  logic        is_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  logic [32:0] mul_sum;
  logic [32:0] rem_shift;
  logic        q_bit;
  logic [31:0] div_diff;

  logic [63:0] prod;
  logic [63:0] prod_neg;
  logic [31:0] fix_hi, fix_lo;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod;
  assign fast_prod = {32'd0, a_mag} * {32'd0, b_mag};
`endif

  assign accept    = (state_q == StIdle) && valid_i && !flush_i;
  assign is_signed = ~op_i[0];
  assign a_neg     = is_signed & a_i[31];
  assign b_neg     = is_signed & b_i[31];
  assign a_mag     = a_neg ? (32'd0 - a_i) : a_i;
  assign b_mag     = b_neg ? (32'd0 - b_i) : b_i;

  // Shift-add step: {hi,lo} holds partial product in hi and remaining multiplier bits in lo.
  assign mul_sum = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opb_q} : 33'd0);

  // Restoring divide step: remainder in hi, dividend/quotient shifting through lo.
  assign rem_shift = {work_hi_q, work_lo_q[31]};
  assign q_bit     = rem_shift >= {1'b0, opb_q};
  assign div_diff  = rem_shift[31:0] - opb_q;

  assign prod     = {work_hi_q, work_lo_q};
  assign prod_neg = 64'd0 - prod;

  always_comb begin
    fix_hi = work_hi_q;
    fix_lo = work_lo_q;
    if (is_div_q) begin
      if (sign_a_q ^ sign_b_q) fix_lo = 32'd0 - work_lo_q;
      if (sign_a_q)            fix_hi = 32'd0 - work_hi_q;
    end else if (sign_a_q ^ sign_b_q) begin
      fix_hi = prod_neg[63:32];
      fix_lo = prod_neg[31:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    opb_d     = opb_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          is_div_d  = op_i[1];
          sign_a_d  = a_neg;
          sign_b_d  = b_neg;
          opb_d     = b_mag;
          cnt_d     = 5'd0;
          work_hi_d = 32'd0;
          work_lo_d = a_mag;
          if (op_i[1]) begin
            if (b_i == 32'd0) begin
              state_d = StDone;
              hi_d    = a_i;
              lo_d    = 32'hFFFF_FFFF;
            end else begin
              state_d = StDiv;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            work_hi_d = fast_prod[63:32];
            work_lo_d = fast_prod[31:0];
            state_d   = StFix;
`else
            state_d   = StMul;
`endif
          end
        end
      end

      StMul: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
          work_hi_d = mul_sum[32:1];
          work_lo_d = {mul_sum[0], work_lo_q[31:1]};
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StFix;
        end
      end

      StDiv: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = 5'd0;
        end else begin
          work_hi_d = q_bit ? div_diff : rem_shift[31:0];
          work_lo_d = {work_lo_q[30:0], q_bit};
          cnt_d     = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = StFix;
        end
      end

      StFix: begin
        if (flush_i) begin
          state_d = StIdle;
        end else begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          state_d = StDone;
        end
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      is_div_q  <= 1'b0;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      opb_q     <= 32'd0;
      work_hi_q <= 32'd0;
      work_lo_q <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sign_a_q  <= sign_a_d;
      sign_b_q  <= sign_b_d;
      opb_q     <= opb_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign ready_o = (state_q == StIdle);
  assign done_o  = (state_q == StDone);
  // Gated by reset so the front-end is released while reset is held.
  assign stall_o = !reset &&
                   (accept || (state_q == StMul) || (state_q == StDiv) || (state_q == StFix));
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized scoreboard bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        flush_i;
  logic        ready_o, stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
    longint      t0;
  } exp_t;

  exp_t sb[$];

  muldiv_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .valid_i (valid_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .flush_i (flush_i),
    .ready_o (ready_o),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero like MIPS.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output int lat);
    longint la, lb, q, r, p;
    la = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    lb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (!op[1]) begin
      p  = la * lb;
      hi = p[63:32];
      lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
      lat = 2;
`else
      lat = 34;
`endif
    end else if (b == 32'd0) begin
      hi  = a;
      lo  = 32'hFFFF_FFFF;
      lat = 1;
    end else begin
      q   = la / lb;
      r   = la % lb;
      hi  = r[31:0];
      lo  = q[31:0];
      lat = 34;
    end
  endfunction

  exp_t   mon_e;
  int     mon_lat;
  logic   prev_stall = 1'b0;

  always @(negedge clk) begin
    if (done_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'd0);
      end else begin
        mon_e   = sb.pop_front();
        mon_lat = int'(($time - mon_e.t0 - 5) / 10) + 1;
        check("hi", {32'd0, hi_o}, {32'd0, mon_e.hi});
        check("lo", {32'd0, lo_o}, {32'd0, mon_e.lo});
        check("latency", 64'(mon_lat), 64'(mon_e.lat));
        check("done_stall_ready", {62'd0, stall_o, ready_o}, 64'd0);
        if (mon_e.lat > 1) check("fix_stall", 64'(prev_stall), 64'd1);
      end
    end
    prev_stall = stall_o;
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (ready_o !== 1'b1) check("ready_timeout", 64'(ready_o), 64'd1);
    #1;
    valid_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    @(posedge clk);
    model(op, a, b, e.hi, e.lo, e.lat);
    e.t0 = $time;
    sb.push_back(e);
    if (hold) @(posedge clk);
    #1;
    valid_i = 1'b0;
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  logic [31:0] saved_hi, saved_lo;
  logic [1:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    reset   = 1'b1;
    valid_i = 1'b0;
    flush_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 32'd0;
    b_i     = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_stall", 64'(stall_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_hilo", {hi_o, lo_o}, 64'd0);
    reset = 1'b0;

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    issue(2'b11, 32'd5, 32'd0, 1'b1);
    issue(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
    issue(2'b11, 32'hFFFF_FFFF, 32'd1, 1'b0);
    issue(2'b10, 32'hFFFF_FFF0, 32'd0, 1'b1);
    drain();

    // Flush a DIVU 100/7 during its 10th DIV cycle.
    saved_hi = hi_o;
    saved_lo = lo_o;
    #1;
    valid_i = 1'b1;
    op_i    = 2'b11;
    a_i     = 32'd100;
    b_i     = 32'd7;
    @(posedge clk);
    #1 valid_i = 1'b0;
    repeat (10) @(negedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk);
    #1 flush_i = 1'b0;
    check("flush_ready", 64'(ready_o), 64'd1);
    check("flush_stall", 64'(stall_o), 64'd0);
    repeat (40) @(negedge clk);
    check("flush_hi", {32'd0, hi_o}, {32'd0, saved_hi});
    check("flush_lo", {32'd0, lo_o}, {32'd0, saved_lo});

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      if ($urandom_range(0, 7) == 0)      rb = 32'd0;
      else if ($urandom_range(0, 1) == 0) rb = $urandom;
      else                                rb = 32'($urandom_range(1, 20));
      issue(rop, ra, rb, 1'($urandom_range(0, 1)));
    end
    drain();

    // Reset in the middle of a multiply, then a fresh multiply.
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drain();
    issue(2'b01, 32'd123, 32'd456, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    #1;
    check("midrst_ready", 64'(ready_o), 64'd1);
    check("midrst_stall", 64'(stall_o), 64'd0);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_hilo", {hi_o, lo_o}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    issue(2'b01, 32'd6, 32'd7, 1'b0);
    drain();
    check("final_lo", {32'd0, lo_o}, 64'd42);
    check("final_hi", {32'd0, hi_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
